// File: rtl/ascon_perm_arbiter.sv
// Two-requester round-robin front end for a shared Ascon permutation core.
// Latches the owner's state and rounds, strobes the core, and aborts if the core stalls.
module ascon_perm_arbiter (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [1:0]   req_i,
    input  logic [3:0]   rounds0_i,
    input  logic [3:0]   rounds1_i,
    input  logic [319:0] state0_i,
    input  logic [319:0] state1_i,
    output logic [1:0]   gnt_o,
    output logic [1:0]   done_o,
    output logic [1:0]   err_o,
    output logic [319:0] state_o,
    output logic         busy_o,
    output logic         perm_start_o,
    output logic [3:0]   perm_rounds_o,
    output logic [319:0] perm_state_o,
    input  logic [319:0] perm_state_i,
    input  logic         perm_done_i
);
    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} fsm_e;

    // Watchdog value seen during the 31st WAIT cycle (counter holds elapsed WAIT cycles).
    localparam logic [4:0] WDOG_LAST = 5'd30;

    fsm_e         state_q, state_d;
    logic         owner_q, owner_d;
    logic         rr_q, rr_d;
    logic [4:0]   wdog_q, wdog_d;
    logic [1:0]   gnt_q, gnt_d;
    logic [1:0]   done_q, done_d;
    logic [1:0]   err_q, err_d;
    logic [319:0] res_q, res_d;
    logic [319:0] pstate_q, pstate_d;
    logic [3:0]   prounds_q, prounds_d;
    logic         busy_q, busy_d;
    logic         start_q, start_d;
    logic         sel;
    logic         ok;

    function automatic logic [3:0] legal_rounds(input logic [3:0] r);
        return (r == 4'd6 || r == 4'd8) ? r : 4'd12;
    endfunction

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_d      = rr_q;
        wdog_d    = wdog_q;
        res_d     = res_q;
        pstate_d  = pstate_q;
        prounds_d = prounds_q;
        gnt_d     = 2'b00;
        done_d    = 2'b00;
        err_d     = 2'b00;
        start_d   = 1'b0;
        ok        = 1'b0;
        sel       = (req_i == 2'b11) ? rr_q : req_i[1];

        case (state_q)
            IDLE: begin
                if (req_i != 2'b00) begin
                    owner_d      = sel;
                    pstate_d     = sel ? state1_i : state0_i;
                    prounds_d    = legal_rounds(sel ? rounds1_i : rounds0_i);
                    gnt_d[sel]   = 1'b1;
                    start_d      = 1'b1;
                    state_d      = START;
                end
            end
            START: begin
                wdog_d  = 5'd0;
                state_d = WAIT;
            end
            WAIT: begin
                wdog_d = wdog_q + 5'd1;
                // Completion is tested first so it wins a tie with the watchdog.
                if (perm_done_i) begin
                    res_d   = perm_state_i;
                    ok      = 1'b1;
                    state_d = RESP;
                end else if (wdog_q == WDOG_LAST) begin
                    state_d = RESP;
                end
                if (state_d == RESP) begin
                    done_d[owner_q] = ok;
                    err_d[owner_q]  = ~ok;
                    rr_d            = ~owner_q;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            rr_q      <= 1'b0;
            wdog_q    <= 5'd0;
            gnt_q     <= 2'b00;
            done_q    <= 2'b00;
            err_q     <= 2'b00;
            res_q     <= '0;
            pstate_q  <= '0;
            prounds_q <= 4'd0;
            busy_q    <= 1'b0;
            start_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_q      <= rr_d;
            wdog_q    <= wdog_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            err_q     <= err_d;
            res_q     <= res_d;
            pstate_q  <= pstate_d;
            prounds_q <= prounds_d;
            busy_q    <= busy_d;
            start_q   <= start_d;
        end
    end

    assign gnt_o         = gnt_q;
    assign done_o        = done_q;
    assign err_o         = err_q;
    assign state_o       = res_q;
    assign busy_o        = busy_q;
    assign perm_start_o  = start_q;
    assign perm_rounds_o = prounds_q;
    assign perm_state_o  = pstate_q;

endmodule
